// File: rtl/dpram_bw_pkg.sv
// Shared types and helpers for the byte-writable dual-port RAM.
package dpram_bw_pkg;

  typedef enum logic {ST_INIT, ST_READY} dpram_bw_state_t;

  localparam int COLL_CNT_WIDTH = 16;

  function automatic int num_bytes(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/dpram_bw_rd_pipe.sv
// Per-port read output pipeline: 1 or 2 register stages for dout/rvalid.
module dpram_bw_rd_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rd_req,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  rvalid
);

  logic                  stg_req;
  logic [DATA_WIDTH-1:0] stg_data;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  v_q;
      logic [DATA_WIDTH-1:0] d_q;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          v_q <= 1'b0;
          d_q <= '0;
        end else begin
          v_q <= rd_req;
          if (rd_req) d_q <= rd_data;
        end
      end

      assign stg_req  = v_q;
      assign stg_data = d_q;
    end else begin : g_lat1
      assign stg_req  = rd_req;
      assign stg_data = rd_data;
    end
  endgenerate

  // dout only moves with a valid read, so it holds across writes and idle cycles
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout   <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= stg_req;
      if (stg_req) dout <= stg_data;
    end
  end

endmodule

// File: rtl/dpram_bw.sv
// True dual-port RAM, per-byte write enables, zero-clear sweep after reset.
// Optional collision counter output enabled by DPRAM_BW_COLLISION_CNT_EN.
//
//   state    | meaning
//   ST_INIT  | clearing address cnt each cycle, all port requests dropped
//   ST_READY | normal operation, left only by reset
module dpram_bw
  import dpram_bw_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8,
  parameter int BYTE_WIDTH    = 8,
  parameter int READ_LATENCY  = 1
) (
  input  logic                                             clk,
  input  logic                                             rstn,
  output logic                                             init_done,
  input  logic                                             ena,
  input  logic [num_bytes(DATA_WIDTH, BYTE_WIDTH)-1:0]     wea,
  input  logic [ADDRESS_WIDTH-1:0]                         addra,
  input  logic [DATA_WIDTH-1:0]                            dina,
  output logic [DATA_WIDTH-1:0]                            douta,
  output logic                                             rvalida,
  input  logic                                             enb,
  input  logic [num_bytes(DATA_WIDTH, BYTE_WIDTH)-1:0]     web,
  input  logic [ADDRESS_WIDTH-1:0]                         addrb,
  input  logic [DATA_WIDTH-1:0]                            dinb,
  output logic [DATA_WIDTH-1:0]                            doutb,
  output logic                                             rvalidb
`ifdef DPRAM_BW_COLLISION_CNT_EN
  ,
  output logic [COLL_CNT_WIDTH-1:0]                        coll_cnt
`endif
);

  localparam int DEPTH     = 2 ** ADDRESS_WIDTH;
  localparam int NUM_BYTES = num_bytes(DATA_WIDTH, BYTE_WIDTH);
  localparam logic [ADDRESS_WIDTH:0] CNT_END = (ADDRESS_WIDTH + 1)'(DEPTH);

  generate
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $fatal(1, "dpram_bw: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
      $fatal(1, "dpram_bw: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
  endgenerate

  dpram_bw_state_t          state;
  logic [ADDRESS_WIDTH:0]   cnt;
  logic [DATA_WIDTH-1:0]    mem [DEPTH];

  logic ready, init_wr;
  logic rd_a, rd_b, wr_a, wr_b;

  assign ready   = (state == ST_READY);
  assign init_wr = (state == ST_INIT) && !cnt[ADDRESS_WIDTH];
  assign rd_a    = ready && ena && (wea == '0);
  assign rd_b    = ready && enb && (web == '0);
  assign wr_a    = ready && ena && (wea != '0);
  assign wr_b    = ready && enb && (web != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_INIT;
      cnt       <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (cnt == CNT_END) begin
            state     <= ST_READY;
            init_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_READY;
      endcase
    end
  end

  // Port A lanes are applied after port B so A wins any same-address lane clash
  always_ff @(posedge clk) begin
    if (init_wr) begin
      mem[cnt[ADDRESS_WIDTH-1:0]] <= '0;
    end else begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (wr_b && web[b]) mem[addrb][b*BYTE_WIDTH +: BYTE_WIDTH] <= dinb[b*BYTE_WIDTH +: BYTE_WIDTH];
      end
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (wr_a && wea[b]) mem[addra][b*BYTE_WIDTH +: BYTE_WIDTH] <= dina[b*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  dpram_bw_rd_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe_a (
    .clk    (clk),
    .rstn   (rstn),
    .rd_req (rd_a),
    .rd_data(mem[addra]),
    .dout   (douta),
    .rvalid (rvalida)
  );

  dpram_bw_rd_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe_b (
    .clk    (clk),
    .rstn   (rstn),
    .rd_req (rd_b),
    .rd_data(mem[addrb]),
    .dout   (doutb),
    .rvalid (rvalidb)
  );

`ifdef DPRAM_BW_COLLISION_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      coll_cnt <= '0;
    end else if (ready && ena && enb && (addra == addrb) && (wr_a || wr_b)
                 && (coll_cnt != {COLL_CNT_WIDTH{1'b1}})) begin
      coll_cnt <= coll_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dpram_bw.sv
// Directed bench for dpram_bw: latency-1 and latency-2 instances, 16-word depth.
module tb_dpram_bw;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;

  logic        ena1, enb1, rva1, rvb1, init1;
  logic [3:0]  wea1, web1, addra1, addrb1;
  logic [31:0] dina1, dinb1, douta1, doutb1;

  logic        ena2, enb2, rva2, rvb2, init2;
  logic [3:0]  wea2, web2, addra2, addrb2;
  logic [31:0] dina2, dinb2, douta2, doutb2;

`ifdef DPRAM_BW_COLLISION_CNT_EN
  logic [15:0] coll1, coll2;
`endif

  dpram_bw #(.DATA_WIDTH(32), .ADDRESS_WIDTH(4), .BYTE_WIDTH(8), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rstn(rstn), .init_done(init1),
    .ena(ena1), .wea(wea1), .addra(addra1), .dina(dina1), .douta(douta1), .rvalida(rva1),
    .enb(enb1), .web(web1), .addrb(addrb1), .dinb(dinb1), .doutb(doutb1), .rvalidb(rvb1)
`ifdef DPRAM_BW_COLLISION_CNT_EN
    , .coll_cnt(coll1)
`endif
  );

  dpram_bw #(.DATA_WIDTH(32), .ADDRESS_WIDTH(4), .BYTE_WIDTH(8), .READ_LATENCY(2)) dut2 (
    .clk(clk), .rstn(rstn), .init_done(init2),
    .ena(ena2), .wea(wea2), .addra(addra2), .dina(dina2), .douta(douta2), .rvalida(rva2),
    .enb(enb2), .web(web2), .addrb(addrb2), .dinb(dinb2), .doutb(doutb2), .rvalidb(rvb2)
`ifdef DPRAM_BW_COLLISION_CNT_EN
    , .coll_cnt(coll2)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ena;
    logic [3:0]  wea;
    logic [3:0]  addra;
    logic [31:0] dina;
    logic        enb;
    logic [3:0]  web;
    logic [3:0]  addrb;
    logic [31:0] dinb;
    logic        rva;
    logic [31:0] douta;
    logic        rvb;
    logic [31:0] doutb;
    logic [15:0] coll;
  } vec_t;

  vec_t vecs[12];

  task automatic idle1();
    ena1 = 1'b0; wea1 = 4'h0; addra1 = 4'h0; dina1 = 32'h0;
    enb1 = 1'b0; web1 = 4'h0; addrb1 = 4'h0; dinb1 = 32'h0;
  endtask

  task automatic idle2();
    ena2 = 1'b0; wea2 = 4'h0; addra2 = 4'h0; dina2 = 32'h0;
    enb2 = 1'b0; web2 = 4'h0; addrb2 = 4'h0; dinb2 = 32'h0;
  endtask

  task automatic drive2a(input logic en, input logic [3:0] we, input logic [3:0] a, input logic [31:0] d);
    ena2 = en; wea2 = we; addra2 = a; dina2 = d;
  endtask

  initial begin
    int n;

    //        ena   wea    addra  dina           enb   web    addrb  dinb           rva   douta          rvb   doutb          coll
    vecs[0]  = '{1'b1, 4'h0, 4'd0,  32'h0,        1'b1, 4'h0, 4'd12, 32'h0,        1'b1, 32'h0,        1'b1, 32'h0,        16'd0};
    vecs[1]  = '{1'b1, 4'hF, 4'd5,  32'hAABBCCDD, 1'b1, 4'hF, 4'd7,  32'hCAFEF00D, 1'b0, 32'h0,        1'b0, 32'h0,        16'd0};
    vecs[2]  = '{1'b1, 4'h0, 4'd7,  32'h0,        1'b0, 4'h0, 4'd0,  32'h0,        1'b1, 32'hCAFEF00D, 1'b0, 32'h0,        16'd0};
    vecs[3]  = '{1'b1, 4'h5, 4'd5,  32'h11223344, 1'b0, 4'h0, 4'd0,  32'h0,        1'b0, 32'hCAFEF00D, 1'b0, 32'h0,        16'd0};
    vecs[4]  = '{1'b0, 4'h0, 4'd0,  32'h0,        1'b1, 4'h0, 4'd5,  32'h0,        1'b0, 32'hCAFEF00D, 1'b1, 32'hAA22CC44, 16'd0};
    vecs[5]  = '{1'b1, 4'h3, 4'd9,  32'h11111111, 1'b1, 4'hF, 4'd9,  32'h22222222, 1'b0, 32'hCAFEF00D, 1'b0, 32'hAA22CC44, 16'd1};
    vecs[6]  = '{1'b1, 4'h0, 4'd9,  32'h0,        1'b1, 4'h0, 4'd9,  32'h0,        1'b1, 32'h22221111, 1'b1, 32'h22221111, 16'd1};
    vecs[7]  = '{1'b1, 4'h0, 4'd3,  32'h0,        1'b1, 4'hF, 4'd3,  32'hDEADBEEF, 1'b1, 32'h0,        1'b0, 32'h22221111, 16'd2};
    vecs[8]  = '{1'b1, 4'h0, 4'd3,  32'h0,        1'b1, 4'h0, 4'd5,  32'h0,        1'b1, 32'hDEADBEEF, 1'b1, 32'hAA22CC44, 16'd2};
    vecs[9]  = '{1'b1, 4'h8, 4'd3,  32'h01000000, 1'b1, 4'h0, 4'd3,  32'h0,        1'b0, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 16'd3};
    vecs[10] = '{1'b1, 4'h0, 4'd15, 32'h0,        1'b1, 4'h0, 4'd3,  32'h0,        1'b1, 32'h0,        1'b1, 32'h01ADBEEF, 16'd3};
    vecs[11] = '{1'b0, 4'h0, 4'd0,  32'h0,        1'b0, 4'h0, 4'd0,  32'h0,        1'b0, 32'h0,        1'b0, 32'h01ADBEEF, 16'd3};

    idle1();
    idle2();
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #1;
    chk("rst_douta1", douta1, 32'h0);
    chk("rst_doutb1", doutb1, 32'h0);
    chk("rst_rvalid1", {30'h0, rva1, rvb1}, 32'h0);
    chk("rst_init1", {31'h0, init1}, 32'h0);
    chk("rst_douta2", douta2, 32'h0);
    chk("rst_rvalid2", {30'h0, rva2, rvb2}, 32'h0);

    // Reads during the sweep are dropped; then reset again at sweep count 7
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 7; i++) begin
      ena1 = 1'b1; wea1 = 4'h0; addra1 = 4'(i);
      @(posedge clk);
      #1 chk("init_early_rvalid", {31'h0, rva1}, 32'h0);
    end
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("midrst_douta", douta1, 32'h0);
    chk("midrst_init", {31'h0, init1}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    n = 0;
    while (n < 40 && !init1) begin
      ena1 = 1'b1; wea1 = 4'hF; addra1 = 4'd0; dina1 = 32'hFFFFFFFF;
      enb1 = 1'b1; web1 = 4'h0; addrb1 = 4'd0;
      @(posedge clk);
      #1;
      n++;
      chk("init_rvalid", {30'h0, rva1, rvb1}, 32'h0);
    end
    chk("sweep_len", 32'(n), 32'd17);
    chk("sweep_init2", {31'h0, init2}, 32'h1);

    @(negedge clk);
    idle1();

    for (int i = 0; i < 12; i++) begin
      ena1 = vecs[i].ena; wea1 = vecs[i].wea; addra1 = vecs[i].addra; dina1 = vecs[i].dina;
      enb1 = vecs[i].enb; web1 = vecs[i].web; addrb1 = vecs[i].addrb; dinb1 = vecs[i].dinb;
      @(negedge clk);
      chk($sformatf("v%0d_rvalida", i), {31'h0, rva1}, {31'h0, vecs[i].rva});
      chk($sformatf("v%0d_douta", i), douta1, vecs[i].douta);
      chk($sformatf("v%0d_rvalidb", i), {31'h0, rvb1}, {31'h0, vecs[i].rvb});
      chk($sformatf("v%0d_doutb", i), doutb1, vecs[i].doutb);
`ifdef DPRAM_BW_COLLISION_CNT_EN
      chk($sformatf("v%0d_coll", i), {16'h0, coll1}, {16'h0, vecs[i].coll});
`endif
    end
    idle1();

    // Latency 2: preload 0..2, then back-to-back reads
    drive2a(1'b1, 4'hF, 4'd0, 32'h0A0A0A0A);
    enb2 = 1'b1; web2 = 4'hF; addrb2 = 4'd1; dinb2 = 32'h0B0B0B0B;
    @(negedge clk);
    chk("lat2_wr_rvalid", {30'h0, rva2, rvb2}, 32'h0);
    enb2 = 1'b0; web2 = 4'h0;
    drive2a(1'b1, 4'hF, 4'd2, 32'h0C0C0C0C);
    @(negedge clk);
    drive2a(1'b1, 4'h0, 4'd0, 32'h0);
    @(negedge clk);
    chk("lat2_c1_rvalid", {31'h0, rva2}, 32'h0);
    drive2a(1'b1, 4'h0, 4'd1, 32'h0);
    @(negedge clk);
    chk("lat2_c2_rvalid", {31'h0, rva2}, 32'h1);
    chk("lat2_c2_douta", douta2, 32'h0A0A0A0A);
    drive2a(1'b1, 4'h0, 4'd2, 32'h0);
    @(negedge clk);
    chk("lat2_c3_rvalid", {31'h0, rva2}, 32'h1);
    chk("lat2_c3_douta", douta2, 32'h0B0B0B0B);
    idle2();
    @(negedge clk);
    chk("lat2_c4_rvalid", {31'h0, rva2}, 32'h1);
    chk("lat2_c4_douta", douta2, 32'h0C0C0C0C);
    @(negedge clk);
    chk("lat2_c5_rvalid", {31'h0, rva2}, 32'h0);
    chk("lat2_c5_douta", douta2, 32'h0C0C0C0C);

    // Asynchronous reset between edges clears non-zero outputs at once
    #2 rstn = 1'b0;
    #1;
    chk("async_doutb1", doutb1, 32'h0);
    chk("async_douta2", douta2, 32'h0);
    chk("async_init", {30'h0, init1, init2}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dpram_bw.md
Name: dpram_bw

Overview:
- Single-clock, true dual-port RAM with per-byte write enables and a configurable read latency 1 or 2.
- Per-port read-valid strobes and a defined collision policy.
- A hardware zero-clear sweep after reset, so the contents are known before use.
- Next-generation shell memory: replaces the word-write, fixed-latency, vendor-macro dual-port RAM with an inferred-array, fully specified block.

Parameters:
- DATA_WIDTH, 32: word width in bits; must be a multiple of BYTE_WIDTH.
- ADDRESS_WIDTH, 8: address bits; DEPTH = 2**ADDRESS_WIDTH words.
- BYTE_WIDTH, 8: bits per write-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH.
- READ_LATENCY, 1: 1 or 2 cycles from read request to data/valid; any other value is a fatal elaboration error.

Ports:
- clk  in  1  single clock for both ports.
- rstn  in  1  asynchronous active-low reset.
- init_done  out  1  high once the clear sweep is complete.
- ena  in  1  port A request.
- wea  in  NUM_BYTES  port A byte write enables; all zero = read.
- addra  in  ADDRESS_WIDTH  port A address.
- dina  in  DATA_WIDTH  port A write data.
- douta  out  DATA_WIDTH  port A read data.
- rvalida  out  1  port A read data valid, one-cycle pulse.
- enb, web, addrb, dinb, doutb, rvalidb: port B equivalents, same widths.

Behaviour:
- Reset (rstn low, async):
  - douta, doutb = 0; rvalida, rvalidb = 0; init_done = 0.
  - FSM enters INIT with the sweep counter at 0.
  - The memory array itself is not reset.
- FSM states:
  - INIT: writes zero to address cnt each cycle, counter increments, for DEPTH cycles. In the cycle after writing DEPTH-1, go to READY and set init_done = 1.
  - READY: terminal state, left only by reset.
  - In INIT all port requests are ignored and dropped, not queued; rvalid stays 0; dout holds 0.
- Reset asserted mid-sweep: restarts from address 0 when released.
- Read request: en=1 and we=0 in READY.
  - Latency 1: dout and rvalid update on the next edge.
  - Latency 2: one additional register stage; rvalid is delayed identically.
  - dout holds its last value when rvalid=0.
- Write request: en=1 and any we bit set. Writes only the enabled byte lanes at addr.
  - No-change mode: the writing port's dout does not change and no rvalid is produced.
- Collisions (both ports enabled, same address, same cycle):
  - Both write: per byte lane, port A wins where its wea bit is set; port B bytes are written only in lanes where wea is clear.
  - One reads, one writes: the reader gets old data (read-first); the new data is visible from the next cycle.
  - Both read: both get the same data.
- The address wraps naturally at ADDRESS_WIDTH bits; no out-of-range check exists.
- Requests are accepted every cycle in READY; there is no backpressure, and throughput is one op per port per cycle.

Optional Feature:
- Macro: DPRAM_BW_COLLISION_CNT_EN.
- Defined:
  - Adds output port coll_cnt (16 bits, reset 0).
  - Increments once per READY cycle where ena&enb, addra==addrb, and at least one port writes.
  - Saturates at 16'hFFFF.
- Undefined: the port and its logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package dpram_bw_pkg holds:
  - typedef enum logic {ST_INIT, ST_READY} dpram_bw_state_t;
  - localparam COLL_CNT_WIDTH = 16;
  - function num_bytes(DATA_WIDTH, BYTE_WIDTH).
- Sub-module dpram_bw_rd_pipe: per-port output pipeline holding dout/rvalid registers, parametrised by READ_LATENCY and DATA_WIDTH, instantiated twice.
- FSM, sweep counter, array and collision merge live in the top level.

Test Plan:
- Sweep timing: release rstn, ADDRESS_WIDTH=4 -> init_done rises exactly 17 cycles after release. A read of any address then returns 0 with rvalida one cycle later (latency 1).
- Byte lanes: write addr 5 with dina=32'hAABBCCDD, wea=4'b1111, then write 32'h11223344 with wea=4'b0101. A port B read of addr 5 returns 32'hAA22CC44, and douta is unchanged during both writes.
- Dual write: same cycle to addr 9, A dina=32'h11111111 wea=4'b0011, B dinb=32'h22222222 web=4'b1111 -> a later read returns 32'h22221111.
- Read-first: addr 3 holds 32'h0, A reads while B writes 32'hDEADBEEF -> douta=0; a next-cycle A read returns 32'hDEADBEEF. With the macro defined, coll_cnt increments 0->1.
- READ_LATENCY=2: issue back-to-back reads of addr 0,1,2 -> rvalida is high for 3 consecutive cycles starting 2 cycles after the first request, with data in order.
- Mid-sweep reset: pulse rstn low at sweep count 7 -> rvalid and dout return to 0 immediately, and init_done only rises DEPTH+1 cycles after release. Requests issued during INIT produce no rvalid and no write.
